// File: rtl/fft_stream_pkg.sv
// Shared types and default widths for the FFT stream host.
package fft_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned SAMPLE_W_DEF   = 16;
    localparam int unsigned IDX_W_DEF      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } host_fsm;

endpackage

// File: rtl/fft_stream_skid.sv
// Two-entry valid/ready buffer between the source memory read port and the AR channel.
// The head entry drives o_data directly, so it only changes when the head is popped.
module fft_stream_skid
    import fft_stream_pkg::*;
#(
    parameter int unsigned W = SAMPLE_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic         v1;
    logic [W-1:0] e1;
    logic         pop_q;

    assign pop_q   = i_pop & o_valid;
    // Second entry is only ever occupied behind a valid head.
    assign o_count = {v1, o_valid & ~v1};

    // Head/second-entry update: refill the head from the second entry on pop.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            v1      <= 1'b0;
            e1      <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            v1      <= 1'b0;
        end else begin
            case ({i_push, pop_q})
                2'b10: begin
                    if (!o_valid) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                    end else begin
                        e1 <= i_data;
                        v1 <= 1'b1;
                    end
                end
                2'b01: begin
                    if (v1) begin
                        o_data <= e1;
                        v1     <= 1'b0;
                    end else begin
                        o_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (v1) begin
                        o_data <= e1;
                        e1     <= i_data;
                    end else begin
                        o_data <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_stream_host.sv
// Host side of the FFT AXI bridge: streams N samples out on AR, drains N results from AW.
// Optional FFT_STREAM_CHECKSUM_EN adds o_checksum, the running sum of accepted results.
module fft_stream_host
    import fft_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [IDX_W-1:0]      i_samples_number,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_src_rd,
    output logic [IDX_W-1:0]      o_src_addr,
    input  logic [SAMPLE_W-1:0]   i_src_data,
    output logic                  o_ARVALID,
    output logic [SAMPLE_W-1:0]   o_ARDATA,
    input  logic                  i_ARREADY,
    input  logic                  i_AWVALID,
    input  logic [DATA_WIDTH-1:0] i_AWDATA,
    output logic                  o_AWREADY,
    output logic                  o_res_wr,
    output logic [IDX_W-1:0]      o_res_addr,
    output logic [DATA_WIDTH-1:0] o_res_data
`ifdef FFT_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] o_checksum
`endif
);

    host_fsm          state;
    logic [IDX_W-1:0] n_lat;
    logic [IDX_W-1:0] rd_cnt;
    logic [IDX_W-1:0] ar_cnt;
    logic [IDX_W-1:0] wr_cnt;
    logic             rd_pend;
    logic [1:0]       skid_count;
    logic [1:0]       credit;
    logic             ar_pop;
    logic             aw_xfer;
    logic             start_ok;

    assign ar_pop   = o_ARVALID & i_ARREADY;
    assign aw_xfer  = i_AWVALID & o_AWREADY;
    assign start_ok = (state == ST_IDLE) & i_start;

    // Slots committed after this cycle: in-flight read plus buffered samples minus the one leaving.
    assign credit     = 2'(rd_pend) + skid_count - 2'(ar_pop);
    // Read strobe is issued the same cycle a slot is known free, giving 1 sample/cycle.
    assign o_src_rd   = (state == ST_SEND) && (rd_cnt != n_lat) && (credit < 2'd2);
    assign o_src_addr = rd_cnt;

    fft_stream_skid #(.W(SAMPLE_W)) u_skid (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_flush (start_ok),
        .i_push  (rd_pend),
        .i_data  (i_src_data),
        .i_pop   (i_ARREADY),
        .o_valid (o_ARVALID),
        .o_data  (o_ARDATA),
        .o_count (skid_count)
    );

    // Control FSM, counters and registered host outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            n_lat      <= '0;
            rd_cnt     <= '0;
            ar_cnt     <= '0;
            wr_cnt     <= '0;
            rd_pend    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_AWREADY  <= 1'b0;
            o_res_wr   <= 1'b0;
            o_res_addr <= '0;
            o_res_data <= '0;
`ifdef FFT_STREAM_CHECKSUM_EN
            o_checksum <= '0;
`endif
        end else begin
            o_done   <= 1'b0;
            o_res_wr <= 1'b0;
            rd_pend  <= o_src_rd;
            if (o_src_rd) begin
                rd_cnt <= rd_cnt + IDX_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        n_lat  <= i_samples_number;
                        rd_cnt <= '0;
                        ar_cnt <= '0;
                        wr_cnt <= '0;
                        o_busy <= 1'b1;
`ifdef FFT_STREAM_CHECKSUM_EN
                        o_checksum <= '0;
`endif
                        if (i_samples_number == '0) begin
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            o_err <= 1'b0;
                            state <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (ar_pop) begin
                        ar_cnt <= ar_cnt + IDX_W'(1);
                        if (ar_cnt == n_lat - IDX_W'(1)) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_AWVALID) begin
                        o_AWREADY <= 1'b1;
                        state     <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (aw_xfer) begin
                        o_res_wr   <= 1'b1;
                        o_res_addr <= wr_cnt;
                        o_res_data <= i_AWDATA;
                        wr_cnt     <= wr_cnt + IDX_W'(1);
`ifdef FFT_STREAM_CHECKSUM_EN
                        o_checksum <= o_checksum + i_AWDATA;
`endif
                        if (wr_cnt == n_lat - IDX_W'(1)) begin
                            o_AWREADY <= 1'b0;
                            o_done    <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
